// File: rtl/booth_ctrl.sv
// rtl/booth_ctrl.sv - sequencing FSM for the 16-bit radix-2 Booth multiplier datapath
module booth_ctrl #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             q0,
  input  logic             q_m1,
  input  logic [CNT_W-1:0] count,
  output logic             ld_m,
  output logic             ld_q,
  output logic             clr_a,
  output logic             clr_qm1,
  output logic             ldcnt,
  output logic             ld_a,
  output logic             alu_sub,
  output logic             shift,
  output logic             dcr,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0] state_q, state_d;
  logic       last_iter;

  // count==0 is a corruption guard so a stale counter can never loop through an underflow
  assign last_iter = (count == CNT_W'(1)) || (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? LOAD : IDLE;
      LOAD:    state_d = CHECK;
      CHECK:   state_d = SHIFT;
      SHIFT:   state_d = last_iter ? DONE : CHECK;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ld_m    = (state_q == LOAD);
  assign ld_q    = (state_q == LOAD);
  assign clr_a   = (state_q == LOAD);
  assign clr_qm1 = (state_q == LOAD);
  assign ldcnt   = (state_q == LOAD);

  // Booth recoding: {q0,q_m1}=10 subtracts M, 01 adds M, 00/11 leave A untouched
  assign ld_a    = (state_q == CHECK) && (q0 ^ q_m1);
  assign alu_sub = (state_q == CHECK) && q0 && !q_m1;

  assign shift   = (state_q == SHIFT);
  assign dcr     = (state_q == SHIFT);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule
